// File: rtl/unet_host_sequencer.sv
// unet_host_sequencer: CPU-free host controller for one inference on the
// accelerator. It streams weights and then input words from a combinational-read
// memory into the accelerator, waits for compute to finish, and writes the
// results back. It reports busy, done and error, and has a watchdog.
module unet_host_sequencer #(
  parameter int WEIGHT_WORDS = 1680,
  parameter int INPUT_WORDS  = 49218,
  parameter int OUTPUT_WORDS = 65536,
  parameter int WEIGHT_BASE  = 0,
  parameter int INPUT_BASE   = 1680,
  parameter int ADDR_W       = 17,
  parameter int TMO_W        = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              skip_weights,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_o,
  input  logic [2:0]        acc_ctrl,
  output logic              acc_enpulse,
  output logic [31:0]       acc_data_in,
  input  logic [31:0]       acc_data_out,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_W = 3'd1,
    S_LOAD_W = 3'd2,
    S_WAIT_D = 3'd3,
    S_LOAD_D = 3'd4,
    S_WAIT_R = 3'd5,
    S_UNLOAD = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Status codes reported by the accelerator on acc_ctrl.
  typedef enum logic [2:0] {
    AC_CALC    = 3'd0,
    AC_SEND_W  = 3'd1,
    AC_SEND_D  = 3'd2,
    AC_READY   = 3'd3,
    AC_SENDING = 3'd4,
    AC_IDLE    = 3'd5
  } acc_code_t;

  localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(WEIGHT_BASE);
  localparam logic [ADDR_W-1:0] D_BASE = ADDR_W'(INPUT_BASE);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(WEIGHT_WORDS - 1);
  localparam logic [ADDR_W-1:0] D_LAST = ADDR_W'(INPUT_WORDS - 1);
  localparam logic [ADDR_W-1:0] O_LAST = ADDR_W'(OUTPUT_WORDS - 1);
  // An idle cycle seen with this value would push wdog to all-ones, so the
  // timeout is taken on that cycle.
  localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [TMO_W-1:0]  wdog;
  logic              xfer;

  assign busy    = (state != S_IDLE);
  assign state_o = state;
  assign wr_data = acc_data_out;

  // Next state, word counter and all transfer-qualified outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_nxt   = state;
    cnt_nxt     = cnt;
    xfer        = 1'b0;
    acc_enpulse = 1'b0;
    acc_data_in = '0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    done        = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = skip_weights ? S_WAIT_D : S_WAIT_W;
      end
      S_WAIT_W: begin
        if (acc_ctrl == AC_IDLE) begin
          acc_enpulse = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        rd_addr     = W_BASE + cnt;
        acc_data_in = rd_data;
        if (acc_ctrl == AC_SEND_W) begin
          xfer = 1'b1;
          if (cnt == W_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT_D;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_WAIT_D: begin
        if (acc_ctrl == AC_IDLE) begin
          acc_enpulse = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_LOAD_D;
        end
      end
      S_LOAD_D: begin
        rd_addr     = D_BASE + cnt;
        acc_data_in = rd_data;
        if (acc_ctrl == AC_SEND_D) begin
          xfer = 1'b1;
          if (cnt == D_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT_R;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_WAIT_R: begin
        if (acc_ctrl == AC_READY) begin
          acc_enpulse = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        wr_addr = cnt;
        if (acc_ctrl == AC_SENDING) begin
          xfer  = 1'b1;
          wr_en = 1'b1;
          if (cnt == O_LAST) begin
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_ERR: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over any word seen in the same cycle; that word is dropped.
    if (abort && state != S_IDLE && state != S_ERR) begin
      state_nxt   = S_ERR;
      cnt_nxt     = cnt;
      xfer        = 1'b0;
      acc_enpulse = 1'b0;
      wr_en       = 1'b0;
      done        = 1'b0;
    end else if (state != S_IDLE && state != S_ERR && state_nxt == state &&
                 !xfer && wdog == TMO_LAST) begin
      state_nxt = S_ERR;
    end
  end

  // State and word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Watchdog: cleared by any progress, otherwise counts busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state_nxt != state || xfer) begin
      wdog <= '0;
    end else if (busy) begin
      wdog <= wdog + 1'b1;
    end
  end

  // Sticky error flag, cleared only when a new run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (state == S_IDLE && start) begin
      error <= 1'b0;
    end else if (state_nxt == S_ERR) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unet_host_sequencer.sv
// Self-checking bench for unet_host_sequencer with a small accelerator BFM,
// a random memory image and a scoreboard of expected reads and writes.
module tb_unet_host_sequencer;

  localparam int WW = 4;
  localparam int IW = 6;
  localparam int OW = 8;
  localparam int WB = 0;
  localparam int IB = 4;
  localparam int AW = 8;
  localparam int TW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          skip_weights;
  logic          abort;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    state_o;
  logic [2:0]    acc_ctrl;
  logic          acc_enpulse;
  logic [31:0]   acc_data_in;
  logic [31:0]   acc_data_out;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic [31:0] mem [256];
  assign rd_data = mem[rd_addr];

  unet_host_sequencer #(
    .WEIGHT_WORDS(WW), .INPUT_WORDS(IW), .OUTPUT_WORDS(OW),
    .WEIGHT_BASE(WB), .INPUT_BASE(IB), .ADDR_W(AW), .TMO_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .skip_weights(skip_weights),
    .abort(abort), .busy(busy), .done(done), .error(error), .state_o(state_o),
    .acc_ctrl(acc_ctrl), .acc_enpulse(acc_enpulse), .acc_data_in(acc_data_in),
    .acc_data_out(acc_data_out), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_enp = 0;
  int n_done = 0;

  // Outputs captured mid-cycle by cycle().
  logic          o_en, o_wr, o_done, o_busy, o_err;
  logic [2:0]    o_state;
  logic [AW-1:0] o_rd_addr, o_wa;
  logic [31:0]   o_din, o_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample on the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    o_en      = acc_enpulse;
    o_wr      = wr_en;
    o_done    = done;
    o_busy    = busy;
    o_err     = error;
    o_state   = state_o;
    o_rd_addr = rd_addr;
    o_din     = acc_data_in;
    o_wa      = wr_addr;
    o_wd      = wr_data;
    if (acc_enpulse) n_enp++;
    if (done) n_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit skip);
    start        = 1'b1;
    skip_weights = skip;
    acc_ctrl     = 3'd5;
    cycle();
    start        = 1'b0;
    skip_weights = 1'b0;
  endtask

  // Present a status code and expect the phase-start pulse on the first cycle.
  task automatic wait_enp(input logic [2:0] code, input logic [2:0] exp_state, input string tag);
    int n = 0;
    bit seen = 0;
    logic [2:0] st = '0;
    acc_ctrl = code;
    while (!seen && n < 20) begin
      cycle();
      n++;
      seen = o_en;
      st   = o_state;
    end
    check({tag, "_lat"}, n, 1);
    check({tag, "_st"}, st, exp_state);
  endtask

  task automatic stall(input int smax, input logic [2:0] exp_state);
    int k = $urandom_range(smax, 0);
    acc_ctrl = 3'd0;
    repeat (k) begin
      cycle();
      check("stall_st", o_state, exp_state);
      check("stall_we", o_wr, 0);
      check("stall_enp", o_en, 0);
    end
  endtask

  // Stream words; the expected address is simply base plus word index.
  task automatic load_phase(input logic [2:0] code, input int base, input int words,
                            input logic [2:0] st, input int smax, input int abort_at);
    for (int i = 0; i < words; i++) begin
      stall(smax, st);
      acc_ctrl = code;
      if (i == abort_at) abort = 1'b1;
      cycle();
      check("rd_addr", o_rd_addr, base + i);
      check("rd_data", o_din, mem[base + i]);
      check("ld_enp", o_en, 0);
      if (i == abort_at) begin
        abort = 1'b0;
        return;
      end
    end
  endtask

  task automatic calc();
    int k = $urandom_range(4, 0);
    acc_ctrl = 3'd0;
    repeat (k) begin
      cycle();
      check("calc_enp", o_en, 0);
    end
  endtask

  task automatic unload_phase(input int smax, input int words);
    logic [31:0] exp;
    for (int i = 0; i < words; i++) begin
      stall(smax, 3'd6);
      acc_ctrl     = 3'd4;
      exp          = $urandom;
      acc_data_out = exp;
      cycle();
      check("wr_en", o_wr, 1);
      check("wr_addr", o_wa, i);
      check("wr_data", o_wd, exp);
      check("done", o_done, (i == OW - 1) ? 1 : 0);
    end
  endtask

  task automatic full_run(input bit skip, input int smax);
    int d0 = n_done;
    int e0 = n_enp;
    do_start(skip);
    if (!skip) begin
      wait_enp(3'd5, 3'd1, "enp_w");
      check("err_clr", o_err, 0);
      load_phase(3'd1, WB, WW, 3'd2, smax, -1);
    end
    wait_enp(3'd5, 3'd3, "enp_d");
    check("err_clr_d", o_err, 0);
    load_phase(3'd2, IB, IW, 3'd4, smax, -1);
    calc();
    wait_enp(3'd3, 3'd5, "enp_r");
    unload_phase(smax, OW);
    acc_ctrl = 3'd5;
    cycle();
    check("end_busy", o_busy, 0);
    check("end_state", o_state, 0);
    check("end_err", o_err, 0);
    check("done_cnt", n_done - d0, 1);
    check("enp_cnt", n_enp - e0, skip ? 2 : 3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit seen;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n        = 1'b0;
    start        = 1'b0;
    skip_weights = 1'b0;
    abort        = 1'b0;
    acc_ctrl     = 3'd5;
    acc_data_out = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_enp", acc_enpulse, 0);
    check("rst_we", wr_en, 0);
    check("rst_rdaddr", rd_addr, 0);
    check("rst_state", state_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    full_run(1'b0, 0);
    full_run(1'b1, 0);
    full_run(1'b0, 3);
    full_run(1'b1, 2);

    // Watchdog: the accelerator never reports READY.
    do_start(1'b0);
    wait_enp(3'd5, 3'd1, "tmo_enp_w");
    load_phase(3'd1, WB, WW, 3'd2, 2, -1);
    wait_enp(3'd5, 3'd3, "tmo_enp_d");
    load_phase(3'd2, IB, IW, 3'd4, 2, -1);
    acc_ctrl = 3'd0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      cycle();
      if (o_err) seen = 1;
      else n++;
    end
    check("tmo_cycles", n, 15);
    check("tmo_state", o_state, 7);
    cycle();
    check("tmo_idle", o_state, 0);
    check("tmo_busy", o_busy, 0);
    check("tmo_err", o_err, 1);
    full_run(1'b0, 1);

    // Abort on input word 3, with start attempts while busy and during ERR.
    d0 = n_done;
    do_start(1'b0);
    wait_enp(3'd5, 3'd1, "ab_enp_w");
    acc_ctrl = 3'd0;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
    cycle();
    check("busy_start", o_state, 2);
    load_phase(3'd1, WB, WW, 3'd2, 1, -1);
    wait_enp(3'd5, 3'd3, "ab_enp_d");
    load_phase(3'd2, IB, IW, 3'd4, 1, 3);
    acc_ctrl = 3'd0;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
    check("ab_err_state", o_state, 7);
    check("ab_err_flag", o_err, 1);
    cycle();
    check("ab_idle", o_state, 0);
    check("ab_busy", o_busy, 0);
    check("ab_err_sticky", o_err, 1);
    check("ab_no_done", n_done - d0, 0);
    full_run(1'b0, 1);

    // Asynchronous reset in the middle of UNLOAD.
    do_start(1'b0);
    wait_enp(3'd5, 3'd1, "rs_enp_w");
    load_phase(3'd1, WB, WW, 3'd2, 0, -1);
    wait_enp(3'd5, 3'd3, "rs_enp_d");
    load_phase(3'd2, IB, IW, 3'd4, 0, -1);
    calc();
    wait_enp(3'd3, 3'd5, "rs_enp_r");
    unload_phase(1, 3);
    acc_ctrl = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", error, 0);
    check("mid_rst_enp", acc_enpulse, 0);
    check("mid_rst_we", wr_en, 0);
    check("mid_rst_rdaddr", rd_addr, 0);
    check("mid_rst_state", state_o, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    acc_ctrl = 3'd5;
    @(posedge clk);
    #1;
    full_run(1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
